// File: rtl/main_core.sv
// ============================================================================
// Module      : main_core
// Description : Programmable clock divider. oCLK toggles every SW cycles of
//               CLK (SW=0 behaves as 1); output is driven from a flip-flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_core (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SW,
    output logic       oCLK
);

    localparam logic [7:0] c_one = 8'd1;

    logic [7:0] w_eff;
    logic       w_wrap;
    logic [7:0] r_cnt;
    logic [7:0] r_hp;
    logic       r_oclk;

    assign w_eff  = (SW == 8'd0) ? c_one : SW;
    // r_hp is never zero, so the subtraction cannot underflow
    assign w_wrap = (r_cnt == (r_hp - c_one));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt  <= 8'd0;
            r_oclk <= 1'b0;
            r_hp   <= w_eff;
        end else if (w_wrap) begin
            // SW is re-sampled only here, so a half-period is never truncated
            r_oclk <= ~r_oclk;
            r_cnt  <= 8'd0;
            r_hp   <= w_eff;
        end else begin
            r_cnt  <= r_cnt + c_one;
        end
    end

    assign oCLK = r_oclk;

endmodule

`default_nettype wire

// File: tb/tb_main_core.sv
// ============================================================================
// Module      : tb_main_core
// Description : Self-checking bench for main_core against an edge-scheduled
//               model of the divider, plus literal half-period expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_core;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] SW  = 8'd5;
    logic       oCLK;

    int checks   = 0;
    int failures = 0;

    main_core dut (
        .CLK  (CLK),
        .RST  (RST),
        .SW   (SW),
        .oCLK (oCLK)
    );

    always #5 CLK = ~CLK;

    // Model: the output toggles at scheduled edge numbers; each schedule
    // step is the half-period latched at reset or at the previous toggle.
    longint edge_idx = 0;
    longint m_next   = 0;
    int     m_hp     = 1;
    logic   m_exp    = 1'b0;
    bit     m_valid  = 1'b0;

    function automatic int eff(input logic [7:0] s);
        return (s == 8'd0) ? 1 : int'(s);
    endfunction

    always @(posedge CLK) begin
        edge_idx = edge_idx + 1;
        if (RST) begin
            m_valid = 1'b1;
            m_exp   = 1'b0;
            m_hp    = eff(SW);
            m_next  = edge_idx + m_hp;
        end else if (m_valid && edge_idx == m_next) begin
            m_exp  = ~m_exp;
            m_hp   = eff(SW);
            m_next = edge_idx + m_hp;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (m_valid) check("oclk_vs_model", int'(oCLK), int'(m_exp));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts CLK edges until oCLK changes; bounded so a stuck output fails.
    task automatic measure(output int n);
        logic prev;
        prev = oCLK;
        n = 0;
        do begin
            tick();
            n = n + 1;
        end while (oCLK === prev && n < 600);
    endtask

    int n;
    int n2;

    initial begin
        // Reset with SW=5 held for 3 cycles
        SW  = 8'd5;
        RST = 1'b1;
        repeat (3) begin
            tick();
            check("reset_low", int'(oCLK), 0);
        end
        RST = 1'b0;
        measure(n);
        check("first_rise_sw5", n, 5);
        check("rise_level", int'(oCLK), 1);
        measure(n);
        check("half_sw5_a", n, 5);
        measure(n);
        check("half_sw5_b", n, 5);

        // Minimum divide, SW=1 then SW=0
        SW = 8'd1;
        measure(n);
        repeat (6) begin
            measure(n);
            check("half_sw1", n, 1);
        end
        SW = 8'd0;
        measure(n);
        repeat (6) begin
            measure(n);
            check("half_sw0", n, 1);
        end

        // Sweep, ending at 255
        for (int v = 1; v <= 255; v = v + 9) begin
            SW = 8'(v);
            measure(n);
            measure(n);
            check("sweep_half", n, v);
        end
        SW = 8'd255;
        measure(n);
        measure(n);
        measure(n2);
        check("period_255", n + n2, 510);

        // Mid-period change from 8 to 2 at cycle 3
        SW = 8'd8;
        measure(n);
        measure(n);
        repeat (3) tick();
        SW = 8'd2;
        measure(n);
        check("mid_change_current", n + 3, 8);
        measure(n);
        check("mid_change_next", n, 2);
        measure(n);
        check("mid_change_next2", n, 2);

        // Reset while oCLK is high
        SW = 8'd4;
        measure(n);
        measure(n);
        if (oCLK !== 1'b1) measure(n);
        check("pre_reset_high", int'(oCLK), 1);
        RST = 1'b1;
        tick();
        check("reset_forces_low", int'(oCLK), 0);
        RST = 1'b0;
        measure(n);
        check("rise_after_reset_sw4", n, 4);

        // Duty cycle with SW=37
        SW = 8'd37;
        measure(n);
        measure(n);
        repeat (10) begin
            measure(n);
            measure(n2);
            check("duty_high_low", n, n2);
            check("duty_half", n, 37);
        end

        // Random SW changes and occasional resets, checked by the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) SW = 8'($urandom_range(0, 12));
            RST = ($urandom_range(0, 299) == 0);
            tick();
        end
        RST = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
